jt6295_chfetch: RTL and testbench

- Four-channel sample fetcher placed between the command/phrase-table controller and the ADPCM decoder.
- Takes the per-channel start/stop requests and the phrase start/stop byte addresses from the controller.
- Time-multiplexes one ADPCM ROM port across the four channels, one slot per cen4.
- Delivers one 4-bit ADPCM nibble per active channel per slot to the decoder, and reports per-channel busy back to the controller.

---
 rtl/jt6295_chfetch_if.sv | 26 ++
 rtl/jt6295_chfetch.sv | 184 ++++++++++++++++++
 tb/tb_jt6295_chfetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_chfetch_if.sv
// ROM port and decoder-side signals of the four-channel ADPCM sample fetcher.
// The fetcher drives the ROM address/request and the decoder strobe bundle.
interface jt6295_chfetch_if;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        dec_en;
    logic [1:0]  dec_ch;
    logic        dec_busy;
    logic [3:0]  dec_data;
    logic [3:0]  dec_att;
    logic        dec_first;

    modport master (
        output rom_addr, rom_cs,
        input  rom_data, rom_ok,
        output dec_en, dec_ch, dec_busy, dec_data, dec_att, dec_first
    );

    modport slave (
        input  rom_addr, rom_cs,
        output rom_data, rom_ok,
        input  dec_en, dec_ch, dec_busy, dec_data, dec_att, dec_first
    );
endinterface

// File: rtl/jt6295_chfetch.sv
// Four-channel ADPCM sample fetcher: one shared ROM port, one slot per cen4,
// one nibble per busy channel per slot handed to the decoder.
module jt6295_chfetch (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen4,
    input  logic [3:0]       start,
    input  logic [3:0]       stop,
    input  logic [17:0]      start_addr,
    input  logic [17:0]      stop_addr,
    input  logic [3:0]       att,
    output logic [3:0]       busy,
    jt6295_chfetch_if.master bus
);
    logic [1:0]  r_slot;
    logic [17:0] r_rom_addr;
    logic        r_rom_cs;
    logic        r_wait;
    logic        r_fetched;
    logic        r_dec_en;
    logic [1:0]  r_dec_ch;
    logic        r_dec_busy;
    logic [3:0]  r_dec_data;
    logic [3:0]  r_dec_att;
    logic        r_dec_first;

    logic [17:0] w_addr [4];
    logic [7:0]  w_buf  [4];
    logic [3:0]  w_att  [4];
    logic [3:0]  w_nib;
    logic [3:0]  w_first;
    logic [3:0]  w_busy;
    logic [3:0]  w_pend;
    logic [1:0]  w_slot_nx;
    logic        w_take;
    logic        w_fetched;
    logic        w_emit;
    logic        w_fetch_go;
    logic [7:0]  w_byte;

    assign w_slot_nx  = r_slot + 2'd1;
    // rom_ok is only trusted from the second clock after the address moved
    assign w_take     = r_rom_cs & ~r_wait & bus.rom_ok;
    assign w_fetched  = r_fetched | w_take;
    assign w_byte     = w_take ? bus.rom_data : w_buf[r_slot];
    assign w_emit     = cen4 & w_busy[r_slot] & ~w_pend[r_slot]
                      & (w_nib[r_slot] | w_fetched);
    assign w_fetch_go = w_busy[w_slot_nx] & ~w_nib[w_slot_nx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [17:0] r_addr;
            logic [17:0] r_end;
            logic [3:0]  r_att;
            logic [7:0]  r_buf;
            logic        r_nib;
            logic        r_first;
            logic        r_busy;
            logic        r_pend;
            logic        r_start_d;
            logic        r_stop_d;
            logic        w_here;
            logic        w_stop_rise;
            logic        w_load;

            assign w_here      = (r_slot == 2'(gi));
            assign w_stop_rise = stop[gi] & ~r_stop_d;
            // a stop edge in the same cycle beats the start edge
            assign w_load      = start[gi] & ~r_start_d & ~w_stop_rise & ~r_busy;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_addr    <= '0;
                    r_end     <= '0;
                    r_att     <= '0;
                    r_buf     <= '0;
                    r_nib     <= 1'b0;
                    r_first   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_pend    <= 1'b0;
                    r_start_d <= 1'b0;
                    r_stop_d  <= 1'b0;
                end else begin
                    r_start_d <= start[gi];
                    r_stop_d  <= stop[gi];
                    if (w_take && w_here) begin
                        r_buf <= bus.rom_data;
                    end
                    if (w_load) begin
                        r_addr  <= start_addr;
                        r_end   <= stop_addr;
                        r_att   <= att;
                        r_nib   <= 1'b0;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pend  <= 1'b0;
                    end else if (cen4 && w_here) begin
                        if (r_busy && r_pend) begin
                            r_busy <= 1'b0;
                        end else if (w_emit) begin
                            r_first <= 1'b0;
                            r_nib   <= ~r_nib;
                            if (r_nib) begin
                                if (r_addr == r_end) begin
                                    r_busy <= 1'b0;
                                end else begin
                                    r_addr <= r_addr + 18'd1;
                                end
                            end
                        end
                        r_pend <= w_stop_rise;
                    end else if (w_stop_rise) begin
                        r_pend <= 1'b1;
                    end
                end
            end

            assign w_addr[gi]  = r_addr;
            assign w_buf[gi]   = r_buf;
            assign w_att[gi]   = r_att;
            assign w_nib[gi]   = r_nib;
            assign w_first[gi] = r_first;
            assign w_busy[gi]  = r_busy;
            assign w_pend[gi]  = r_pend;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= '0;
            r_rom_addr  <= '0;
            r_rom_cs    <= 1'b0;
            r_wait      <= 1'b0;
            r_fetched   <= 1'b0;
            r_dec_en    <= 1'b0;
            r_dec_ch    <= '0;
            r_dec_busy  <= 1'b0;
            r_dec_data  <= '0;
            r_dec_att   <= '0;
            r_dec_first <= 1'b0;
        end else begin
            r_wait      <= 1'b0;
            r_dec_en    <= 1'b0;
            r_dec_ch    <= '0;
            r_dec_busy  <= 1'b0;
            r_dec_data  <= '0;
            r_dec_att   <= '0;
            r_dec_first <= 1'b0;
            if (w_take) begin
                r_fetched <= 1'b1;
                r_rom_cs  <= 1'b0;
            end
            if (cen4) begin
                r_slot    <= w_slot_nx;
                r_dec_en  <= 1'b1;
                r_dec_ch  <= r_slot;
                r_dec_att <= w_att[r_slot];
                if (w_emit) begin
                    r_dec_busy  <= 1'b1;
                    r_dec_first <= w_first[r_slot];
                    r_dec_data  <= w_nib[r_slot] ? w_byte[3:0] : w_byte[7:4];
                end
                // an unfinished fetch is abandoned here and retried next visit
                r_fetched <= 1'b0;
                r_rom_cs  <= w_fetch_go;
                r_wait    <= w_fetch_go;
                if (w_fetch_go) begin
                    r_rom_addr <= w_addr[w_slot_nx];
                end
            end
        end
    end

    assign busy          = w_busy;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.rom_cs    = r_rom_cs & ~rst;
    assign bus.dec_en    = r_dec_en;
    assign bus.dec_ch    = r_dec_ch;
    assign bus.dec_busy  = r_dec_busy;
    assign bus.dec_data  = r_dec_data;
    assign bus.dec_att   = r_dec_att;
    assign bus.dec_first = r_dec_first;
endmodule

// File: tb/tb_jt6295_chfetch.sv
// Bench for jt6295_chfetch: directed phrases plus random start/stop traffic,
// checked each cycle against a nibble-position model of the four channels.
`timescale 1ns/1ps
module tb_jt6295_chfetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen4 = 1'b0;
    logic [3:0]  start = '0;
    logic [3:0]  stop = '0;
    logic [17:0] start_addr = '0;
    logic [17:0] stop_addr = '0;
    logic [3:0]  att = '0;
    logic [3:0]  busy;

    jt6295_chfetch_if bus ();

    jt6295_chfetch dut (
        .rst        (rst),
        .clk        (clk),
        .cen4       (cen4),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .att        (att),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cen_period = 4;
    int cen_cnt    = 0;
    int ok_pct     = 100;
    int cap_ch     = 0;
    logic [4:0]  capq [$];
    logic [17:0] fetq [$];

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        logic [7:0] h;
        if (a == 18'h00100) return 8'hA5;
        if (a == 18'h00101) return 8'h3C;
        h = (a[7:0] * 8'd37) ^ {a[15:10], a[17:16]} ^ 8'h5A;
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: channels as nibble positions ----------------
    bit          m_busy [4];
    bit          m_pend [4];
    int          m_pos  [4];
    int          m_len  [4];
    logic [17:0] m_base [4];
    logic [3:0]  m_att  [4];
    logic [7:0]  m_buf  [4];
    int          m_slot;
    bit          m_cs;
    logic [17:0] m_faddr;
    int          m_age;
    bit          m_fetched;
    logic [3:0]  m_start_prev, m_stop_prev;
    bit          e_dec_en, e_dec_busy, e_dec_first;
    logic [1:0]  e_dec_ch;
    logic [3:0]  e_dec_data, e_dec_att;

    function automatic logic [3:0] m_busy_vec();
        return {m_busy[3], m_busy[2], m_busy[1], m_busy[0]};
    endfunction

    always @(posedge clk) begin : model_step
        logic [3:0] srise, prise;
        bit b0 [4];
        int s, ns;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] = 0; m_pend[i] = 0; m_pos[i] = 0; m_len[i] = 0;
                m_base[i] = '0; m_att[i] = '0; m_buf[i] = '0;
            end
            m_slot = 0; m_cs = 0; m_faddr = '0; m_age = 0; m_fetched = 0;
            m_start_prev = '0; m_stop_prev = '0;
            e_dec_en = 0; e_dec_busy = 0; e_dec_first = 0;
            e_dec_ch = '0; e_dec_data = '0; e_dec_att = '0;
        end else begin
            srise = start & ~m_start_prev;
            prise = stop & ~m_stop_prev;
            m_start_prev = start;
            m_stop_prev  = stop;
            for (int i = 0; i < 4; i++) b0[i] = m_busy[i];
            if (m_cs && m_age >= 1 && bus.rom_ok) begin
                m_buf[m_slot] = rom_byte(m_faddr);
                m_fetched = 1;
                m_cs = 0;
            end
            m_age++;
            e_dec_en = 0; e_dec_busy = 0; e_dec_first = 0;
            e_dec_ch = '0; e_dec_data = '0; e_dec_att = '0;
            if (cen4) begin
                s = m_slot;
                e_dec_en  = 1;
                e_dec_ch  = 2'(s);
                e_dec_att = m_att[s];
                if (b0[s]) begin
                    if (m_pend[s]) begin
                        m_busy[s] = 0;
                    end else if ((m_pos[s] % 2) == 1 || m_fetched) begin
                        e_dec_busy  = 1;
                        e_dec_first = (m_pos[s] == 0);
                        e_dec_data  = ((m_pos[s] % 2) == 1) ? m_buf[s][3:0] : m_buf[s][7:4];
                        m_pos[s]++;
                        if (m_pos[s] == m_len[s]) m_busy[s] = 0;
                    end
                end
                m_pend[s] = 0;
                m_slot = (s + 1) % 4;
                m_cs = 0;
                m_fetched = 0;
                ns = m_slot;
                if (b0[ns] && (m_pos[ns] % 2) == 0) begin
                    m_cs = 1;
                    m_faddr = 18'(m_base[ns] + 18'(m_pos[ns] / 2));
                    m_age = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (prise[i]) begin
                    m_pend[i] = 1;
                end else if (srise[i] && !b0[i]) begin
                    m_base[i] = start_addr;
                    m_len[i]  = 2 * (int'(18'(stop_addr - start_addr)) + 1);
                    m_pos[i]  = 0;
                    m_att[i]  = att;
                    m_busy[i] = 1;
                    m_pend[i] = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    always @(posedge clk) begin
        #1;
        chk("busy",     32'(busy),         32'(m_busy_vec()));
        chk("rom_cs",   32'(bus.rom_cs),   32'(m_cs));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_faddr));
        chk("dec_en",   32'(bus.dec_en),   32'(e_dec_en));
        if (e_dec_en) begin
            chk("dec_ch",    32'(bus.dec_ch),    32'(e_dec_ch));
            chk("dec_att",   32'(bus.dec_att),   32'(e_dec_att));
            chk("dec_busy",  32'(bus.dec_busy),  32'(e_dec_busy));
            chk("dec_data",  32'(bus.dec_data),  32'(e_dec_data));
            chk("dec_first", 32'(bus.dec_first), 32'(e_dec_first));
        end
        if (bus.dec_en && bus.dec_busy && bus.dec_ch == 2'(cap_ch))
            capq.push_back({bus.dec_first, bus.dec_data});
        if (bus.dec_en && bus.rom_cs && (bus.dec_ch + 2'd1) == 2'(cap_ch))
            fetq.push_back(bus.rom_addr);
    end

    // ---------------- slot enable and ROM responder ----------------
    always @(negedge clk) begin
        if (cen_cnt >= cen_period - 1) begin
            cen4 = 1'b1;
            cen_cnt = 0;
        end else begin
            cen4 = 1'b0;
            cen_cnt++;
        end
    end

    always @(negedge clk) begin
        if (m_cs && m_age == 0) begin
            bus.rom_ok   = 1'($urandom_range(0, 1));
            bus.rom_data = ~rom_byte(bus.rom_addr);
        end else if (m_cs) begin
            bus.rom_ok   = ($urandom_range(0, 99) < ok_pct);
            bus.rom_data = bus.rom_ok ? rom_byte(bus.rom_addr) : 8'($urandom);
        end else begin
            bus.rom_ok   = 1'($urandom_range(0, 1));
            bus.rom_data = 8'($urandom);
        end
    end

    // ---------------- helpers ----------------
    task automatic begin_tx(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                            input logic [3:0] at);
        capq.delete();
        fetq.delete();
        cap_ch     = ch;
        start_addr = sa;
        stop_addr  = ea;
        att        = at;
        start[ch]  = 1'b1;
    endtask

    task automatic wait_idle(input logic [3:0] mask, input int budget, input string name);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy & mask) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 32'(busy & mask), 32'h0);
    endtask

    function automatic logic [31:0] capv(input int i);
        return (capq.size() > i) ? 32'(capq[i]) : 32'hFFFF;
    endfunction

    function automatic logic [31:0] fetv(input int i);
        return (fetq.size() > i) ? 32'(fetq[i]) : 32'hFFFFF;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0]  exp1 [4];
        logic [7:0]  b;
        logic [17:0] a;
        int ch, len, n;

        exp1[0] = 5'h1A; exp1[1] = 5'h05; exp1[2] = 5'h03; exp1[3] = 5'h0C;
        bus.rom_ok = 1'b0;
        bus.rom_data = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),          32'h0);
        chk("reset_rom_cs", 32'(bus.rom_cs),    32'h0);
        chk("reset_dec_en", 32'(bus.dec_en),    32'h0);
        chk("reset_addr",   32'(bus.rom_addr),  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // basic phrase on ch0
        begin_tx(0, 18'h00100, 18'h00101, 4'h5);
        wait_idle(4'b0001, 400, "t1");
        start[0] = 1'b0;
        $display("TX t1: ch0 0x00100-0x00101 nibbles=%0d", capq.size());
        chk("t1_count", 32'(capq.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_nibble", capv(i), 32'(exp1[i]));

        // ch1 and ch3 together
        @(negedge clk);
        begin_tx(1, 18'h01000, 18'h01002, 4'h9);
        start[3] = 1'b1;
        wait_idle(4'b1010, 600, "t2");
        start = '0;
        $display("TX t2: ch1+ch3 0x01000-0x01002 ch1 nibbles=%0d fetches=%0d", capq.size(), fetq.size());
        chk("t2_nibbles", 32'(capq.size()), 32'd6);
        chk("t2_fetches", 32'(fetq.size()), 32'd3);

        // ROM stalls through slot 2
        @(negedge clk);
        ok_pct = 0;
        begin_tx(2, 18'h04000, 18'h04001, 4'h3);
        repeat (20) @(negedge clk);
        ok_pct = 100;
        wait_idle(4'b0100, 600, "t3");
        start[2] = 1'b0;
        $display("TX t3: ch2 stalled 0x04000-0x04001 fetches=%0d", fetq.size());
        b = rom_byte(18'h04000);
        chk("t3_fetch0", fetv(0), 32'h04000);
        chk("t3_retry",  fetv(1), 32'h04000);
        chk("t3_nibbles", 32'(capq.size()), 32'd4);
        chk("t3_first", capv(0), 32'({1'b1, b[7:4]}));

        // stop mid-phrase then restart
        @(negedge clk);
        begin_tx(2, 18'h05000, 18'h0500F, 4'h7);
        repeat (60) @(negedge clk);
        stop[2] = 1'b1;
        wait_idle(4'b0100, 100, "t4");
        chk("t4_cut", 32'(capq.size() < 32), 32'd1);
        $display("TX t4: ch2 stopped after %0d nibbles", capq.size());
        stop[2] = 1'b0;
        start[2] = 1'b0;
        @(negedge clk);
        begin_tx(2, 18'h06000, 18'h06000, 4'h1);
        wait_idle(4'b0100, 400, "t4r");
        start[2] = 1'b0;
        $display("TX t4r: ch2 restart 0x06000 nibbles=%0d", capq.size());
        chk("t4_restart_n", 32'(capq.size()), 32'd2);
        chk("t4_restart_first", capv(0) >> 4, 32'd1);

        // address wrap
        @(negedge clk);
        begin_tx(0, 18'h3FFFF, 18'h00000, 4'hC);
        wait_idle(4'b0001, 400, "t5");
        start[0] = 1'b0;
        $display("TX t5: ch0 wrap 0x3FFFF-0x00000 nibbles=%0d", capq.size());
        chk("t5_fetch0", fetv(0), 32'h3FFFF);
        chk("t5_fetch1", fetv(1), 32'h00000);
        chk("t5_nibbles", 32'(capq.size()), 32'd4);

        // start edge on a busy channel is ignored
        @(negedge clk);
        begin_tx(0, 18'h00300, 18'h00303, 4'h2);
        repeat (20) @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        start_addr = 18'h20000;
        stop_addr  = 18'h20003;
        start[0]   = 1'b1;
        wait_idle(4'b0001, 800, "t6");
        start[0] = 1'b0;
        $display("TX t6: ch0 0x00300-0x00303 with ignored restart, fetches=%0d", fetq.size());
        chk("t6_fetch0", fetv(0), 32'h00300);
        chk("t6_fetch3", fetv(3), 32'h00303);
        chk("t6_nibbles", 32'(capq.size()), 32'd8);

        // reset in the middle of a fetch
        @(negedge clk);
        ok_pct = 0;
        begin_tx(0, 18'h00400, 18'h00410, 4'h4);
        n = 0;
        while (!bus.rom_cs && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_fetch_seen", 32'(bus.rom_cs), 32'd1);
        rst = 1'b1;
        start = '0;
        ok_pct = 100;
        #1;
        chk("t7_rom_cs_now", 32'(bus.rom_cs), 32'd0);
        @(negedge clk);
        chk("t7_busy", 32'(busy), 32'h0);
        chk("t7_rom_cs", 32'(bus.rom_cs), 32'd0);
        rst = 1'b0;
        $display("TX t7: reset during fetch");

        // random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) begin
                cen_period = $urandom_range(2, 6);
                ok_pct = $urandom_range(30, 100);
            end
            if ($urandom_range(0, 15) == 0) begin
                ch = $urandom_range(0, 3);
                if (start[ch]) begin
                    if (!m_busy[ch]) start[ch] = 1'b0;
                end else begin
                    len = $urandom_range(1, 4);
                    a = ($urandom_range(0, 9) == 0) ? 18'h3FFFE : 18'($urandom);
                    start_addr = a;
                    stop_addr  = 18'(a + 18'(len - 1));
                    att        = 4'($urandom);
                    start[ch]  = 1'b1;
                    $display("TX rnd: start ch%0d 0x%05h-0x%05h att=%0h", ch, start_addr, stop_addr, att);
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                ch = $urandom_range(0, 3);
                stop[ch] = ~stop[ch];
            end
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b1;
                start = '0;
                stop = '0;
                $display("TX rnd: reset");
            end else begin
                rst = 1'b0;
            end
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
